// File: rtl/asm_check_pkg.sv
// Shared types for the assembly result checker: FSM states, check-entry record, index width.
package asm_check_pkg;

    localparam int DEF_XLEN     = 32;
    localparam int DEF_NUM_REGS = 32;
    localparam int REG_IDX_W    = $clog2(DEF_NUM_REGS);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_WAIT_FLAG,
        ST_COMPARE,
        ST_PASS,
        ST_FAIL,
        ST_TIMEOUT
    } state_t;

    typedef struct packed {
        logic [DEF_XLEN-1:0]  flag;
        logic [REG_IDX_W-1:0] reg_idx;
        logic [DEF_XLEN-1:0]  value;
        logic                 last;
    } chk_entry_t;

endpackage

// File: rtl/asm_result_checker_shadow_regfile.sv
// Shadow copy of the CPU register file: one snooped write port, two combinational read ports.
module shadow_regfile #(
    parameter int XLEN     = 32,
    parameter int NUM_REGS = 32,
    parameter int IDX_W    = $clog2(NUM_REGS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_addr,
    input  logic [XLEN-1:0]  wr_data,
    input  logic [IDX_W-1:0] rd_flag_addr,
    output logic [XLEN-1:0]  rd_flag_data,
    input  logic [IDX_W-1:0] rd_cmp_addr,
    output logic [XLEN-1:0]  rd_cmp_data
);

    logic [XLEN-1:0] regs [NUM_REGS];

    // x0 is cleared on reset and never written, so it always reads zero
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else if (wr_en && (wr_addr != '0)) begin
            regs[wr_addr] <= wr_data;
        end
    end

    assign rd_flag_data = regs[rd_flag_addr];
    assign rd_cmp_data  = regs[rd_cmp_addr];

endmodule

// File: rtl/asm_result_checker.sv
// Synthesizable assembly result checker: waits for a progress flag, then compares a register.
// IDLE wait start | FETCH take entry | WAIT_FLAG poll flag | COMPARE check reg | PASS/FAIL/TIMEOUT hold
module asm_result_checker import asm_check_pkg::*; #(
    parameter int XLEN              = 32,
    parameter int NUM_REGS          = 32,
    parameter int FLAG_REG          = 20,
    parameter int TIMEOUT_CYCLES    = 100,
    parameter int PER_STAGE_TIMEOUT = 0,
    parameter int TEST_NUM_W        = 11
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        wb_en,
    input  logic [$clog2(NUM_REGS)-1:0] wb_addr,
    input  logic [XLEN-1:0]             wb_data,
    input  logic                        start,
    input  logic                        chk_valid,
    output logic                        chk_ready,
    input  logic [XLEN-1:0]             chk_flag,
    input  logic [$clog2(NUM_REGS)-1:0] chk_reg,
    input  logic [XLEN-1:0]             chk_value,
    input  logic                        chk_last,
    output logic                        busy,
    output logic                        pass,
    output logic                        fail,
    output logic                        timeout,
    output logic [TEST_NUM_W-1:0]       test_num,
    output logic [$clog2(NUM_REGS)-1:0] fail_reg,
    output logic [XLEN-1:0]             fail_got
);

    localparam int IDX_W = $clog2(NUM_REGS);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    state_t            state, state_nxt;
    logic [XLEN-1:0]   lat_flag, lat_value;
    logic [IDX_W-1:0]  lat_reg;
    logic              lat_last;
    logic [CNT_W-1:0]  cnt, cnt_inc;
    logic [XLEN-1:0]   flag_data, cmp_data;
    logic              busy_st, budget_hit, flag_hit, cmp_ok;

    shadow_regfile #(
        .XLEN     (XLEN),
        .NUM_REGS (NUM_REGS),
        .IDX_W    (IDX_W)
    ) u_shadow (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (wb_en),
        .wr_addr      (wb_addr),
        .wr_data      (wb_data),
        .rd_flag_addr (IDX_W'(FLAG_REG)),
        .rd_flag_data (flag_data),
        .rd_cmp_addr  (lat_reg),
        .rd_cmp_data  (cmp_data)
    );

    assign busy_st    = (state == ST_FETCH) || (state == ST_WAIT_FLAG) || (state == ST_COMPARE);
    assign cnt_inc    = cnt + CNT_W'(1);
    assign budget_hit = busy_st && (cnt_inc == CNT_W'(TIMEOUT_CYCLES));
    assign flag_hit   = (flag_data == lat_flag);
    assign cmp_ok     = (cmp_data == lat_value);

    assign chk_ready = (state == ST_FETCH);
    assign busy      = busy_st;
    assign pass      = (state == ST_PASS);
    assign fail      = (state == ST_FAIL);
    assign timeout   = (state == ST_TIMEOUT);

    // start restarts from any state; an exhausted budget beats a same-cycle match
    always_comb begin
        state_nxt = state;
        if (start) begin
            state_nxt = ST_FETCH;
        end else if (budget_hit) begin
            state_nxt = ST_TIMEOUT;
        end else begin
            case (state)
                ST_FETCH:     if (chk_valid) state_nxt = ST_WAIT_FLAG;
                ST_WAIT_FLAG: if (flag_hit) state_nxt = ST_COMPARE;
                ST_COMPARE:   state_nxt = cmp_ok ? (lat_last ? ST_PASS : ST_FETCH) : ST_FAIL;
                default:      state_nxt = state;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            test_num  <= '0;
            fail_reg  <= '0;
            fail_got  <= '0;
            lat_flag  <= '0;
            lat_reg   <= '0;
            lat_value <= '0;
            lat_last  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (start) begin
                cnt      <= '0;
                test_num <= '0;
                fail_reg <= '0;
                fail_got <= '0;
            end else begin
                if (busy_st) begin
                    if ((PER_STAGE_TIMEOUT != 0) && (state == ST_WAIT_FLAG) && flag_hit && !budget_hit)
                        cnt <= '0;
                    else
                        cnt <= cnt_inc;
                end
                if ((state == ST_FETCH) && chk_valid) begin
                    lat_flag  <= chk_flag;
                    lat_reg   <= chk_reg;
                    lat_value <= chk_value;
                    lat_last  <= chk_last;
                end
                if ((state == ST_COMPARE) && !budget_hit) begin
                    if (cmp_ok) begin
                        test_num <= test_num + TEST_NUM_W'(1);
                    end else begin
                        fail_reg <= lat_reg;
                        fail_got <= cmp_data;
                    end
                end
            end
        end
    end

endmodule
